// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// The pipeline side (master) reports hazard sources; the controller (slave) returns enables, flushes and counters.
interface pipeline_hazard_ctrl_if;
   logic [3:0]  if_id_rs;
   logic [3:0]  if_id_rt;
   logic        rs_used;
   logic        rt_used;
   logic        id_ex_memread;
   logic [3:0]  id_ex_rd;
   logic        branch_taken;
   logic        halt_id;
   logic        imem_busy;
   logic        dmem_busy;
   logic        pc_wen;
   logic        if_id_wen;
   logic        id_ex_wen;
   logic        ex_mem_wen;
   logic        mem_wb_wen;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output if_id_rs, if_id_rt, rs_used, rt_used, id_ex_memread, id_ex_rd,
             branch_taken, halt_id, imem_busy, dmem_busy,
      input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
             if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  if_id_rs, if_id_rt, rs_used, rt_used, id_ex_memread, id_ex_rd,
             branch_taken, halt_id, imem_busy, dmem_busy,
      output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
             if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use, branch, memory-busy
// stalls and HLT drain, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   state_e      state_q, state_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic hazard;
   logic pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
   logic if_id_flush, id_ex_flush, halted;

   assign hazard = hz.id_ex_memread && (hz.id_ex_rd != 4'd0) &&
                   ((hz.rs_used && (hz.id_ex_rd == hz.if_id_rs)) ||
                    (hz.rt_used && (hz.id_ex_rd == hz.if_id_rt)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // A data-memory freeze holds state and drain progress in every state.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      if (!hz.dmem_busy) begin
         case (state_q)
            RUN: begin
               if (!hazard && hz.halt_id) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
            DRAIN: begin
               drain_cnt_d = drain_cnt_q + 2'd1;
               if (drain_cnt_q == 2'd2) state_d = HALTED;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_wen   = 1'b0;
      ex_mem_wen  = 1'b0;
      mem_wb_wen  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;
      if (!rst) begin
         case (state_q)
            HALTED: halted = 1'b1;
            DRAIN: begin
               if (!hz.dmem_busy) begin
                  if_id_wen   = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_wen   = 1'b1;
                  id_ex_flush = 1'b1;
                  ex_mem_wen  = 1'b1;
                  mem_wb_wen  = 1'b1;
               end
            end
            default: begin
               if (!hz.dmem_busy) begin
                  ex_mem_wen = 1'b1;
                  mem_wb_wen = 1'b1;
                  id_ex_wen  = 1'b1;
                  if (hazard) begin
                     id_ex_flush = 1'b1;
                  end else if (hz.halt_id) begin
                     if_id_wen   = 1'b1;
                     if_id_flush = 1'b1;
                  end else if (hz.branch_taken) begin
                     pc_wen      = 1'b1;
                     if_id_wen   = 1'b1;
                     if_id_flush = 1'b1;
                  end else if (hz.imem_busy) begin
                     if_id_wen   = 1'b1;
                     if_id_flush = 1'b1;
                  end else begin
                     pc_wen    = 1'b1;
                     if_id_wen = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((state_q != HALTED) && !pc_wen && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 16'd1;
      if ((if_id_flush || id_ex_flush) && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   assign hz.pc_wen      = pc_wen;
   assign hz.if_id_wen   = if_id_wen;
   assign hz.id_ex_wen   = id_ex_wen;
   assign hz.ex_mem_wen  = ex_mem_wen;
   assign hz.mem_wb_wen  = mem_wb_wen;
   assign hz.if_id_flush = if_id_flush;
   assign hz.id_ex_flush = id_ex_flush;
   assign hz.halted      = halted;
   assign hz.stall_cnt   = stall_cnt_q;
   assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected controls/counters,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .hz  (bus)
   );

   // {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id_flush, id_ex_flush}
   localparam logic [6:0] ALL  = 7'b11111_00;
   localparam logic [6:0] NONE = 7'b00000_00;
   localparam logic [6:0] LU   = 7'b00111_01;
   localparam logic [6:0] FLF  = 7'b01111_10;
   localparam logic [6:0] BR   = 7'b11111_10;
   localparam logic [6:0] DRN  = 7'b01111_11;

   typedef struct {
      string       name;
      logic [6:0]  ctl;
      logic        h;
      logic [15:0] st;
      logic [15:0] fl;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   logic [15:0] exp_stall = '0;
   logic [15:0] exp_flush = '0;

   initial begin
      bus.if_id_rs = '0;  bus.if_id_rt = '0;
      bus.rs_used = 1'b0; bus.rt_used = 1'b0;
      bus.id_ex_memread = 1'b0; bus.id_ex_rd = '0;
      bus.branch_taken = 1'b0; bus.halt_id = 1'b0;
      bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0;
   end

   // us = {rs_used, rt_used}; ev = {branch_taken, halt_id, imem_busy, dmem_busy}
   task automatic cyc(input string nm, input logic r, input logic [3:0] rs, input logic [3:0] rt,
                      input logic [1:0] us, input logic mr, input logic [3:0] rd,
                      input logic [3:0] ev, input logic [6:0] eo, input logic eh, input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      bus.if_id_rs = rs; bus.if_id_rt = rt;
      bus.rs_used = us[1]; bus.rt_used = us[0];
      bus.id_ex_memread = mr; bus.id_ex_rd = rd;
      bus.branch_taken = ev[3]; bus.halt_id = ev[2];
      bus.imem_busy = ev[1]; bus.dmem_busy = ev[0];
      if (chk) begin
         e.name = nm; e.ctl = eo; e.h = eh; e.st = exp_stall; e.fl = exp_flush;
         q.push_back(e);
      end
      if (r) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (!eh && !eo[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
         if ((eo[1] || eo[0]) && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [6:0] act;
         e = q.pop_front();
         act = {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen, bus.ex_mem_wen, bus.mem_wb_wen,
                bus.if_id_flush, bus.id_ex_flush};
         total = total + 4;
         if (act !== e.ctl) begin
            bad = bad + 1;
            $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
         end
         if (bus.halted !== e.h) begin
            bad = bad + 1;
            $display("FAIL %s halted: got %b want %b", e.name, bus.halted, e.h);
         end
         if (bus.stall_cnt !== e.st) begin
            bad = bad + 1;
            $display("FAIL %s stall_cnt: got %h want %h", e.name, bus.stall_cnt, e.st);
         end
         if (bus.flush_cnt !== e.fl) begin
            bad = bad + 1;
            $display("FAIL %s flush_cnt: got %h want %h", e.name, bus.flush_cnt, e.fl);
         end
      end
   end

   initial begin
      cyc("rst0",      1, 0, 0, 2'b00, 0, 0, 4'b0000, NONE, 0, 0);
      cyc("rst1",      1, 0, 0, 2'b00, 0, 0, 4'b0000, NONE, 0, 1);
      cyc("idle",      0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      // load-use on rs, then rd==0 and unused-rt variants
      cyc("lu_rs",     0, 3, 0, 2'b10, 1, 3, 4'b0000, LU,   0, 1);
      cyc("post_lu",   0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      cyc("lu_rd0",    0, 0, 0, 2'b10, 1, 0, 4'b0000, ALL,  0, 1);
      cyc("lu_rt",     0, 5, 5, 2'b01, 1, 5, 4'b0000, LU,   0, 1);
      cyc("rt_unused", 0, 4, 5, 2'b10, 1, 5, 4'b0000, ALL,  0, 1);
      // branch/halt masked by load-use
      cyc("lu_br",     0, 7, 0, 2'b10, 1, 7, 4'b1000, LU,   0, 1);
      cyc("br",        0, 7, 0, 2'b10, 0, 7, 4'b1000, BR,   0, 1);
      cyc("lu_halt",   0, 2, 0, 2'b10, 1, 2, 4'b0100, LU,   0, 1);
      cyc("imem1",     0, 0, 0, 2'b00, 0, 0, 4'b0010, FLF,  0, 1);
      cyc("imem2",     0, 0, 0, 2'b00, 0, 0, 4'b0010, FLF,  0, 1);
      cyc("imem_br",   0, 0, 0, 2'b00, 0, 0, 4'b1010, BR,   0, 1);
      // freeze beats hazard + branch, then hazard re-evaluates
      cyc("frz_run",   0, 6, 0, 2'b10, 1, 6, 4'b1001, NONE, 0, 1);
      cyc("frz_rel",   0, 6, 0, 2'b10, 1, 6, 4'b1000, LU,   0, 1);
      cyc("idle2",     0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      // HLT drain with a 3-cycle freeze at drain_cnt=1
      cyc("halt",      0, 0, 0, 2'b00, 0, 0, 4'b0100, FLF,  0, 1);
      cyc("drn0",      0, 0, 0, 2'b00, 0, 0, 4'b0000, DRN,  0, 1);
      cyc("drn_frz1",  0, 0, 0, 2'b00, 0, 0, 4'b0001, NONE, 0, 1);
      cyc("drn_frz2",  0, 0, 0, 2'b00, 0, 0, 4'b0001, NONE, 0, 1);
      cyc("drn_frz3",  0, 0, 0, 2'b00, 0, 0, 4'b0001, NONE, 0, 1);
      cyc("drn1",      0, 0, 0, 2'b00, 0, 0, 4'b0000, DRN,  0, 1);
      cyc("drn2",      0, 0, 0, 2'b00, 0, 0, 4'b0000, DRN,  0, 1);
      cyc("halted1",   0, 0, 0, 2'b00, 0, 0, 4'b1100, NONE, 1, 1);
      cyc("halted2",   0, 0, 0, 2'b00, 0, 0, 4'b0011, NONE, 1, 1);
      cyc("rst_hlt",   1, 0, 0, 2'b00, 0, 0, 4'b0000, NONE, 0, 1);
      cyc("run_again", 0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      // reset in the middle of a drain
      cyc("halt_b",    0, 0, 0, 2'b00, 0, 0, 4'b0100, FLF,  0, 1);
      cyc("drn_b0",    0, 0, 0, 2'b00, 0, 0, 4'b0000, DRN,  0, 1);
      cyc("rst_drn",   1, 0, 0, 2'b00, 0, 0, 4'b0000, NONE, 0, 1);
      cyc("run_b",     0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      // saturation: continuous imem stall raises both counters past 0xFFFF
      for (int i = 0; i < 65540; i++)
         cyc("sat", 0, 0, 0, 2'b00, 0, 0, 4'b0010, FLF, 0, 0);
      cyc("sat_a",     0, 0, 0, 2'b00, 0, 0, 4'b0010, FLF,  0, 1);
      cyc("sat_b",     0, 0, 0, 2'b00, 0, 0, 4'b0000, ALL,  0, 1);
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
